vram_arbiter: RTL and testbench

//  Shares the single-port async video SRAM between two requesters: the scanout reader (reads)
//  and the command-receiver data path (writes, address from its auto-incrementing generator).

---
 rtl/vram_pkg.sv | 29 ++
 rtl/vram_arbiter_if.sv | 35 +++
 rtl/vram_wr_fifo.sv | 64 ++++++
 rtl/vram_arbiter.sv | 126 ++++++++++++
 tb/tb_vram_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// Shared types and constants for the video SRAM arbiter.
// Holds the FSM encoding, default bus widths and SRAM pin levels.
package vram_pkg;

    localparam int AWIDTH_DEF = 18;
    localparam int DWIDTH_DEF = 8;

    // SRAM control strobes are active-low
    localparam logic SRAM_ON  = 1'b0;
    localparam logic SRAM_OFF = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ADDR  = 3'd1,
        ST_RD_LATCH = 3'd2,
        ST_WR_SETUP = 3'd3,
        ST_WR_PULSE = 3'd4,
        ST_WR_HOLD  = 3'd5
    } state_e;

    function automatic logic is_rd_state(state_e s);
        return (s == ST_RD_ADDR) || (s == ST_RD_LATCH);
    endfunction

    function automatic logic is_wr_state(state_e s);
        return (s == ST_WR_SETUP) || (s == ST_WR_PULSE) || (s == ST_WR_HOLD);
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester and SRAM pin bundle of the video SRAM arbiter.
// slave = arbiter side, master = requesters plus the SRAM device.
interface vram_arbiter_if #(
    parameter int AWIDTH   = vram_pkg::AWIDTH_DEF,
    parameter int DWIDTH   = vram_pkg::DWIDTH_DEF,
    parameter int FIFOLOG2 = 2
);
    logic                WrReqIn;
    logic [AWIDTH-1:0]   WrAddrIn;
    logic [DWIDTH-1:0]   WrDataIn;
    logic                WrReadyOut;
    logic [FIFOLOG2:0]   FifoLevelOut;
    logic                RdReqIn;
    logic [AWIDTH-1:0]   RdAddrIn;
    logic                RdAckOut;
    logic [DWIDTH-1:0]   RdDataOut;
    logic [AWIDTH-1:0]   MemAddrOut;
    logic [DWIDTH-1:0]   MemDataOut;
    logic                MemDataOeOut;
    logic [DWIDTH-1:0]   MemDataIn;
    logic                MemOeNOut;
    logic                MemWeNOut;

    modport slave (
        input  WrReqIn, WrAddrIn, WrDataIn, RdReqIn, RdAddrIn, MemDataIn,
        output WrReadyOut, FifoLevelOut, RdAckOut, RdDataOut,
        output MemAddrOut, MemDataOut, MemDataOeOut, MemOeNOut, MemWeNOut
    );

    modport master (
        output WrReqIn, WrAddrIn, WrDataIn, RdReqIn, RdAddrIn, MemDataIn,
        input  WrReadyOut, FifoLevelOut, RdAckOut, RdDataOut,
        input  MemAddrOut, MemDataOut, MemDataOeOut, MemOeNOut, MemWeNOut
    );
endinterface

// File: rtl/vram_wr_fifo.sv
// Synchronous write-buffer FIFO with occupancy output.
// A full FIFO refuses pushes even on an edge that also pops.
module vram_wr_fifo #(
    parameter int WIDTH = 26,
    parameter int LOG2  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_in,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_in,
    output logic [WIDTH-1:0] head_out,
    output logic [LOG2:0]    level_out,
    output logic             ready_out
);
    localparam int DEPTH = 1 << LOG2;
    localparam logic [LOG2:0]   LVL_FULL = (LOG2 + 1)'(DEPTH);
    localparam logic [LOG2:0]   LVL_ONE  = (LOG2 + 1)'(1);
    localparam logic [LOG2-1:0] PTR_ONE  = LOG2'(1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [LOG2-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LOG2:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign ready_out = (level_q != LVL_FULL);
    assign level_out = level_q;
    assign head_out  = store[rd_ptr_q];
    assign push_ok   = push_in & ready_out;
    assign pop_ok    = pop_in & (level_q != '0);

    always_comb begin
        // NOTE: defaults first, so no path through this block can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage has no reset; the level counter alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) store[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/vram_arbiter.sv
// Video SRAM arbiter: read-priority FSM with starvation limit, buffered writes,
// and registered SRAM pins decoded from the next state so they never glitch.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AWIDTH      = AWIDTH_DEF,
    parameter int DWIDTH      = DWIDTH_DEF,
    parameter int FIFOLOG2    = 2,
    parameter int STARVELIMIT = 8
) (
    input logic           ClkIn,
    input logic           RstIn,
    vram_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVELIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVELIMIT);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    state_e              state_q, state_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic [AWIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_doe_q, mem_doe_d;
    logic                mem_oe_n_q, mem_oe_n_d;
    logic                mem_we_n_q, mem_we_n_d;
    logic                rd_ack_q, rd_ack_d;
    logic [DWIDTH-1:0]   rd_data_q, rd_data_d;

    logic                fifo_pop, fifo_nonempty, wr_first;
    logic [AWIDTH+DWIDTH-1:0] fifo_head;
    logic [FIFOLOG2:0]   fifo_level;

    vram_wr_fifo #(
        .WIDTH (AWIDTH + DWIDTH),
        .LOG2  (FIFOLOG2)
    ) u_wr_fifo (
        .clk       (ClkIn),
        .rst       (RstIn),
        .push_in   (bus.WrReqIn),
        .push_data ({bus.WrAddrIn, bus.WrDataIn}),
        .pop_in    (fifo_pop),
        .head_out  (fifo_head),
        .level_out (fifo_level),
        .ready_out (bus.WrReadyOut)
    );

    assign bus.FifoLevelOut = fifo_level;
    assign fifo_nonempty    = (fifo_level != '0);
    assign wr_first         = fifo_nonempty & (~bus.RdReqIn | (starve_q == STARVE_MAX));

    always_ff @(posedge ClkIn or posedge RstIn) begin
        if (RstIn) begin
            state_q     <= ST_IDLE;
            starve_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_doe_q   <= 1'b0;
            mem_oe_n_q  <= SRAM_OFF;
            mem_we_n_q  <= SRAM_OFF;
            rd_ack_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_doe_q   <= mem_doe_d;
            mem_oe_n_q  <= mem_oe_n_d;
            mem_we_n_q  <= mem_we_n_d;
            rd_ack_q    <= rd_ack_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Every transaction falls back to Idle for one cycle: that is the bus turnaround.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_first) begin
                    state_d  = ST_WR_SETUP;
                    fifo_pop = 1'b1;
                    starve_d = '0;
                end else if (bus.RdReqIn) begin
                    state_d = ST_RD_ADDR;
                    if (!fifo_nonempty)             starve_d = '0;
                    else if (starve_q != STARVE_MAX) starve_d = starve_q + STARVE_ONE;
                end else begin
                    starve_d = '0;
                end
            end
            ST_RD_ADDR:  state_d = ST_RD_LATCH;
            ST_RD_LATCH: state_d = ST_IDLE;
            ST_WR_SETUP: state_d = ST_WR_PULSE;
            ST_WR_PULSE: state_d = ST_WR_HOLD;
            ST_WR_HOLD:  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_q == ST_IDLE && state_d == ST_WR_SETUP) begin
            {mem_addr_d, mem_wdata_d} = fifo_head;
        end else if (state_q == ST_IDLE && state_d == ST_RD_ADDR) begin
            mem_addr_d = bus.RdAddrIn;
        end
        mem_oe_n_d = is_rd_state(state_d) ? SRAM_ON : SRAM_OFF;
        mem_we_n_d = (state_d == ST_WR_PULSE) ? SRAM_ON : SRAM_OFF;
        mem_doe_d  = is_wr_state(state_d);
        rd_ack_d   = (state_q == ST_RD_LATCH);
        rd_data_d  = (state_q == ST_RD_LATCH) ? bus.MemDataIn : rd_data_q;
    end

    assign bus.MemAddrOut   = mem_addr_q;
    assign bus.MemDataOut   = mem_wdata_q;
    assign bus.MemDataOeOut = mem_doe_q;
    assign bus.MemOeNOut    = mem_oe_n_q;
    assign bus.MemWeNOut    = mem_we_n_q;
    assign bus.RdAckOut     = rd_ack_q;
    assign bus.RdDataOut    = rd_data_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vram_arbiter;
    localparam int AW    = 18;
    localparam int DW    = 8;
    localparam int FL    = 2;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic ClkIn = 1'b0;
    logic RstIn = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    vram_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW), .FIFOLOG2(FL)) bus ();

    vram_arbiter #(
        .AWIDTH(AW), .DWIDTH(DW), .FIFOLOG2(FL), .STARVELIMIT(LIMIT)
    ) dut (
        .ClkIn (ClkIn),
        .RstIn (RstIn),
        .bus   (bus)
    );

    always #5 ClkIn = ~ClkIn;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 60) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // ---------------- SRAM device and reference memory ----------------
    logic [DW-1:0] sram    [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge ClkIn)
        if (bus.MemWeNOut === 1'b0 && bus.MemDataOeOut === 1'b1) sram[bus.MemAddrOut] = bus.MemDataOut;

    always @(negedge ClkIn) begin
        if (bus.MemOeNOut === 1'b0)
            bus.MemDataIn = sram.exists(bus.MemAddrOut) ? sram[bus.MemAddrOut] : dflt(bus.MemAddrOut);
        else
            bus.MemDataIn = '0;
    end

    // ---------------- behavioural model ----------------
    // A transaction is a fixed number of bus cycles: a read holds the bus 2 cycles,
    // a write 3; the arbiter then idles one cycle and decides again.
    logic [AW+DW-1:0] mq[$];
    int            starve  = 0;
    int            tx_left = 0;
    int            step    = 0;
    bit            tx_wr   = 0;
    bit            push_m;
    logic [AW-1:0] e_addr  = '0;
    logic [DW-1:0] e_wdata = '0;
    logic [DW-1:0] e_rdata = '0;
    bit            e_ack   = 0;

    always @(posedge ClkIn or posedge RstIn) begin
        if (RstIn) begin
            mq.delete();
            starve = 0; tx_left = 0; step = 0; tx_wr = 0;
            e_addr = '0; e_wdata = '0; e_rdata = '0; e_ack = 0;
        end else begin
            push_m = bus.WrReqIn && (mq.size() < DEPTH);
            e_ack  = 0;
            if (tx_left == 0) begin
                if (mq.size() > 0 && (!bus.RdReqIn || starve == LIMIT)) begin
                    {e_addr, e_wdata} = mq.pop_front();
                    ref_mem[e_addr] = e_wdata;
                    tx_wr = 1; tx_left = 3; step = 0; starve = 0;
                end else if (bus.RdReqIn) begin
                    e_addr = bus.RdAddrIn;
                    tx_wr = 0; tx_left = 2; step = 0;
                    starve = (mq.size() > 0) ? ((starve == LIMIT) ? LIMIT : starve + 1) : 0;
                end else begin
                    starve = 0;
                end
            end else begin
                tx_left--;
                step++;
                if (tx_left == 0 && !tx_wr) begin
                    e_ack   = 1;
                    e_rdata = ref_mem.exists(e_addr) ? ref_mem[e_addr] : dflt(e_addr);
                end
            end
            if (push_m) mq.push_back({bus.WrAddrIn, bus.WrDataIn});
        end
    end

    always @(negedge ClkIn) begin
        check("we_n",  bus.MemWeNOut,   !(tx_left > 0 && tx_wr && step == 1));
        check("oe_n",  bus.MemOeNOut,   !(tx_left > 0 && !tx_wr));
        check("doe",   bus.MemDataOeOut, (tx_left > 0 && tx_wr));
        check("addr",  bus.MemAddrOut,   e_addr);
        check("wdata", bus.MemDataOut,   e_wdata);
        check("ack",   bus.RdAckOut,     e_ack);
        check("rdata", bus.RdDataOut,    e_rdata);
        check("level", bus.FifoLevelOut, mq.size());
        check("ready", bus.WrReadyOut,   mq.size() < DEPTH);
        check("oe_doe_overlap", (!bus.MemOeNOut) & bus.MemDataOeOut, 1'b0);
    end

    // Transaction log (0 = read completed, 1 = write strobe) for the starvation test
    bit log_en = 0;
    bit tlog[$];
    always @(negedge ClkIn) begin
        if (log_en) begin
            if (bus.RdAckOut === 1'b1)  tlog.push_back(1'b0);
            if (bus.MemWeNOut === 1'b0) tlog.push_back(1'b1);
        end
    end

    task automatic idle_inputs();
        bus.WrReqIn = 0; bus.WrAddrIn = '0; bus.WrDataIn = '0;
        bus.RdReqIn = 0; bus.RdAddrIn = '0;
    endtask

    task automatic apply_reset();
        @(negedge ClkIn); #2;
        RstIn = 1'b1;
        idle_inputs();
        @(negedge ClkIn); @(negedge ClkIn); #2;
        RstIn = 1'b0;
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [4:0] t1_we_exp;
        logic [4:0] t1_doe_exp;
        int k, writes;

        idle_inputs();
        bus.MemDataIn = '0;
        t1_we_exp  = 5'b11011;
        t1_doe_exp = 5'b01110;

        // ---- reset state ----
        @(negedge ClkIn); @(negedge ClkIn); #2;
        RstIn = 1'b0;
        @(negedge ClkIn);
        check("rst_we_n", bus.MemWeNOut, 1'b1);
        check("rst_oe_n", bus.MemOeNOut, 1'b1);
        check("rst_doe", bus.MemDataOeOut, 1'b0);
        check("rst_addr", bus.MemAddrOut, 18'h0);
        check("rst_level", bus.FifoLevelOut, 3'd0);
        check("rst_ready", bus.WrReadyOut, 1'b1);
        check("rst_ack", bus.RdAckOut, 1'b0);
        check("rst_rdata", bus.RdDataOut, 8'h00);

        // ---- 1: single write ----
        apply_reset();
        @(negedge ClkIn);
        bus.WrReqIn = 1; bus.WrAddrIn = 18'h12345; bus.WrDataIn = 8'hA5;
        @(posedge ClkIn); #1;
        bus.WrReqIn = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ClkIn);
            check($sformatf("t1_we_n_c%0d", i), bus.MemWeNOut, t1_we_exp[i]);
            check($sformatf("t1_doe_c%0d", i), bus.MemDataOeOut, t1_doe_exp[i]);
            if (i >= 1 && i <= 3) begin
                check($sformatf("t1_addr_c%0d", i), bus.MemAddrOut, 18'h12345);
                check($sformatf("t1_data_c%0d", i), bus.MemDataOut, 8'hA5);
            end
        end

        // ---- 2: single read, device returns 0x3C ----
        apply_reset();
        sram[18'h00010] = 8'h3C;
        ref_mem[18'h00010] = 8'h3C;
        @(negedge ClkIn);
        bus.RdReqIn = 1; bus.RdAddrIn = 18'h00010;
        @(negedge ClkIn);
        check("t2_oe_n_c0", bus.MemOeNOut, 1'b0);
        check("t2_ack_c0", bus.RdAckOut, 1'b0);
        @(negedge ClkIn);
        check("t2_oe_n_c1", bus.MemOeNOut, 1'b0);
        check("t2_ack_c1", bus.RdAckOut, 1'b0);
        @(negedge ClkIn);
        check("t2_ack_c2", bus.RdAckOut, 1'b1);
        check("t2_rdata", bus.RdDataOut, 8'h3C);
        check("t2_oe_n_c2", bus.MemOeNOut, 1'b1);
        bus.RdReqIn = 0;
        @(negedge ClkIn);
        check("t2_ack_pulse", bus.RdAckOut, 1'b0);
        check("t2_rdata_held", bus.RdDataOut, 8'h3C);

        // ---- 3: reads held continuously, two writes queued ----
        apply_reset();
        tlog.delete();
        log_en = 1;
        @(negedge ClkIn);
        bus.RdReqIn = 1; bus.RdAddrIn = 18'h00020;
        bus.WrReqIn = 1; bus.WrAddrIn = 18'h00100; bus.WrDataIn = 8'h11;
        @(negedge ClkIn);
        bus.WrAddrIn = 18'h00101; bus.WrDataIn = 8'h22;
        @(negedge ClkIn);
        bus.WrReqIn = 0;
        k = 0;
        writes = 0;
        while (writes < 2 && k < 300) begin
            @(negedge ClkIn);
            writes = 0;
            foreach (tlog[j]) if (tlog[j]) writes++;
            k++;
        end
        log_en = 0;
        if (writes < 2) timeout_fail("t3_writes");
        check("t3_log_len", tlog.size(), 19);
        for (int i = 0; i < 19; i++)
            if (i < tlog.size()) check($sformatf("t3_slot%0d", i), tlog[i], (i == 9 || i == 18));
        check("t3_level_empty", bus.FifoLevelOut, 3'd0);

        // ---- 4: five writes back-to-back with reads pending ----
        apply_reset();
        @(negedge ClkIn);
        bus.RdReqIn = 1; bus.RdAddrIn = 18'h00030;
        for (int i = 0; i < 4; i++) begin
            bus.WrReqIn = 1; bus.WrAddrIn = 18'h00200 + 18'(i); bus.WrDataIn = 8'h40 + 8'(i);
            @(negedge ClkIn);
        end
        check("t4_level_full", bus.FifoLevelOut, 3'd4);
        check("t4_ready_low", bus.WrReadyOut, 1'b0);
        bus.WrAddrIn = 18'h00204; bus.WrDataIn = 8'h44;
        @(negedge ClkIn);
        check("t4_held_level", bus.FifoLevelOut, 3'd4);
        k = 0;
        while (bus.WrReadyOut !== 1'b1 && k < 300) begin
            @(negedge ClkIn);
            k++;
        end
        if (k >= 300) timeout_fail("t4_ready");
        check("t4_no_bypass_level", bus.FifoLevelOut, 3'd3);
        @(negedge ClkIn);
        bus.WrReqIn = 0;
        check("t4_refill_level", bus.FifoLevelOut, 3'd4);
        check("t4_refill_ready", bus.WrReadyOut, 1'b0);

        // ---- 5: reset during the write strobe ----
        apply_reset();
        @(negedge ClkIn);
        bus.WrReqIn = 1; bus.WrAddrIn = 18'h3FFF0; bus.WrDataIn = 8'h01;
        @(negedge ClkIn);
        bus.WrAddrIn = 18'h3FFF1; bus.WrDataIn = 8'h02;
        @(negedge ClkIn);
        bus.WrAddrIn = 18'h3FFF2; bus.WrDataIn = 8'h03;
        @(negedge ClkIn);
        bus.WrReqIn = 0;
        k = 0;
        while (bus.MemWeNOut !== 1'b0 && k < 20) begin
            @(negedge ClkIn);
            k++;
        end
        if (k >= 20) timeout_fail("t5_we_pulse");
        check("t5_level_pre", bus.FifoLevelOut, 3'd2);
        #2;
        RstIn = 1'b1;
        #1;
        check("t5_we_n_async", bus.MemWeNOut, 1'b1);
        check("t5_doe_async", bus.MemDataOeOut, 1'b0);
        check("t5_level_async", bus.FifoLevelOut, 3'd0);
        check("t5_ack_async", bus.RdAckOut, 1'b0);
        @(negedge ClkIn); #2;
        RstIn = 1'b0;
        @(negedge ClkIn);
        check("t5_we_n_after", bus.MemWeNOut, 1'b1);

        // ---- 6: randomized mixed traffic, small address window for read hits ----
        apply_reset();
        for (int c = 0; c < 2500; c++) begin
            @(posedge ClkIn); #1;
            if (bus.RdReqIn == 1'b0 || bus.RdAckOut == 1'b1) begin
                bus.RdReqIn  = ($urandom_range(0, 2) != 0);
                bus.RdAddrIn = 18'($urandom_range(0, 15));
            end
            bus.WrReqIn  = ($urandom_range(0, 3) == 0);
            bus.WrAddrIn = 18'($urandom_range(0, 15));
            bus.WrDataIn = 8'($urandom);
        end
        idle_inputs();
        repeat (8) @(negedge ClkIn);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
